// File: rtl/btb_update_sched_pkg.sv
// btb_update_sched_pkg: shared types for the BTB update scheduler.
// Holds the ROB->BTB update bus, the queued entry format, the chooser
// counter encoding and the scheduler FSM encoding.
package btb_update_sched_pkg;

    // Number of commit slots presented by the ROB each cycle.
    localparam int NUM_SLOTS = 2;

    // Commit-time control-flow update as seen by the BTB.
    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        branch_inst;
        logic        jal_inst;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } rob_to_btb_bus;

    // Queue entry: the update plus the per-predictor outcome bits that
    // train the chooser when the entry finally issues.
    typedef struct packed {
        rob_to_btb_bus bus;
        logic          bimod_ok;
        logic          gshare_ok;
    } btb_sched_entry_t;

    // 2-bit tournament chooser counter; MSB set selects gshare.
    typedef enum logic [1:0] {
        SB = 2'd0,
        WB = 2'd1,
        WG = 2'd2,
        SG = 2'd3
    } chooser_state_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } btb_sched_state_t;

    // Saturating chooser update: move toward whichever predictor alone
    // got it right; hold when both or neither were right.
    function automatic logic [1:0] chooser_next(input logic [1:0] cur,
                                                input logic       bimod_ok,
                                                input logic       gshare_ok);
        logic [1:0] nxt;
        nxt = cur;
        if (gshare_ok && !bimod_ok && (cur != SG))
            nxt = cur + 2'd1;
        else if (bimod_ok && !gshare_ok && (cur != SB))
            nxt = cur - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: dual-push, single-pop FIFO of scheduler entries.
// Push slot 0 is the older entry; when only slot 1 pushes it lands in the
// first free location, so the caller never has to compact the slots.
// The caller guarantees there is room for every push it asserts.
module btb_upd_fifo
    import btb_update_sched_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int QUEUE_PTR_BITS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic             [NUM_SLOTS-1:0]     push,
    input  btb_sched_entry_t [NUM_SLOTS-1:0]     push_data,
    input  logic                                 pop,
    output btb_sched_entry_t                     head,
    output logic             [QUEUE_PTR_BITS:0]  count
);

    btb_sched_entry_t          mem [QUEUE_DEPTH];
    logic [QUEUE_PTR_BITS-1:0] wr_ptr;
    logic [QUEUE_PTR_BITS-1:0] rd_ptr;
    logic [QUEUE_PTR_BITS-1:0] wr_ptr_1;

    // Slot 1 writes just after slot 0 when both push, else at wr_ptr.
    assign wr_ptr_1 = wr_ptr + QUEUE_PTR_BITS'(push[0]);
    assign head     = mem[rd_ptr];

    // Entry storage needs no reset; count/pointers define what is live.
    always_ff @(posedge clk) begin
        if (push[0]) mem[wr_ptr]   <= push_data[0];
        if (push[1]) mem[wr_ptr_1] <= push_data[1];
    end

    // Pointers wrap naturally at QUEUE_DEPTH (power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + QUEUE_PTR_BITS'(push[0]) + QUEUE_PTR_BITS'(push[1]);
            rd_ptr <= rd_ptr + QUEUE_PTR_BITS'(pop);
            count  <= count + (QUEUE_PTR_BITS+1)'(push[0])
                            + (QUEUE_PTR_BITS+1)'(push[1])
                            - (QUEUE_PTR_BITS+1)'(pop);
        end
    end

endmodule

// File: rtl/btb_update_sched.sv
// btb_update_sched: buffers up to two commit-time branch/jal updates per
// cycle and drains them to the single-ported BTB one per cycle. Owns the
// bimodal/gshare tournament chooser and a drain-then-clear sequence.
// Optional build macro BTB_SCHED_BYPASS_EN: a lone qualifying commit that
// finds the queue empty (RUN, no hold) goes straight to the BTB port.
module btb_update_sched
    import btb_update_sched_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int QUEUE_PTR_BITS = 2,
    parameter int CHOOSER_BITS   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  rob_to_btb_bus        commit0,
    input  rob_to_btb_bus        commit1,
    input  logic [1:0]           commit_bimod_ok,
    input  logic [1:0]           commit_gshare_ok,
    output logic                 commit_ready,
    input  logic                 btb_hold,
    output rob_to_btb_bus        btb_upd,
    input  logic [31:0]          pc_at_fetch,
    output logic                 predictor_choice,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic                 clear_done
);

    localparam int                      TBL_DEPTH = 1 << CHOOSER_BITS;
    localparam logic [CHOOSER_BITS-1:0] WALK_LAST = '1;

    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_CLEAR = CLEAR;

    logic [1:0]                state;
    logic [CHOOSER_BITS-1:0]   walk;
    logic [1:0]                chooser [TBL_DEPTH];

    logic [QUEUE_PTR_BITS:0]   count;
    btb_sched_entry_t          head;

    rob_to_btb_bus    [NUM_SLOTS-1:0] slot;
    btb_sched_entry_t [NUM_SLOTS-1:0] slot_ent;
    logic             [NUM_SLOTS-1:0] qual;
    logic             [NUM_SLOTS-1:0] push;

    logic                    issue;
    logic                    bypass;
    btb_sched_entry_t        bypass_ent;
    logic                    upd_fire;
    btb_sched_entry_t        upd_ent;
    logic                    train;
    logic [CHOOSER_BITS-1:0] train_idx;
    logic [CHOOSER_BITS-1:0] fetch_idx;
    logic                    unused_fetch_bits;

    assign slot[0] = commit0;
    assign slot[1] = commit1;

    // Headroom for two is judged on the registered count only.
    assign commit_ready = (count <= (QUEUE_PTR_BITS+1)'(QUEUE_DEPTH-2));

    // Per-slot qualification: only valid control-flow commits with room.
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        assign qual[s]     = slot[s].valid && slot[s].ready
                          && (slot[s].branch_inst || slot[s].jal_inst)
                          && commit_ready;
        assign slot_ent[s] = {slot[s], commit_bimod_ok[s], commit_gshare_ok[s]};
    end

`ifdef BTB_SCHED_BYPASS_EN
    assign bypass     = (count == '0) && (state == S_RUN) && !btb_hold
                     && (qual[0] ^ qual[1]);
    assign bypass_ent = qual[0] ? slot_ent[0] : slot_ent[1];
`else
    assign bypass     = 1'b0;
    assign bypass_ent = '0;
`endif

    // A bypassed commit is consumed by the port and never enqueued.
    assign push  = bypass ? '0 : qual;
    assign issue = (count != '0) && !btb_hold && (state != S_CLEAR);

    btb_upd_fifo #(
        .QUEUE_DEPTH    (QUEUE_DEPTH),
        .QUEUE_PTR_BITS (QUEUE_PTR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (slot_ent),
        .pop       (issue),
        .head      (head),
        .count     (count)
    );

    // Select what drives the BTB port this cycle; idle drives all zeros.
    always_comb begin
        upd_fire = issue || bypass;
        upd_ent  = '0;
        if (issue)
            upd_ent = head;
        else if (bypass)
            upd_ent = bypass_ent;
    end

    assign btb_upd   = upd_fire ? upd_ent.bus : '0;
    assign train     = upd_fire && upd_ent.bus.branch_inst;
    assign train_idx = upd_ent.bus.pc[CHOOSER_BITS+1:2];

    // Chooser table: full re-init on reset, walk-clear in CLEAR, else train.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TBL_DEPTH; i++)
                chooser[i] <= WB;
        end else if (state == S_CLEAR) begin
            chooser[walk] <= WB;
        end else if (train) begin
            chooser[train_idx] <= chooser_next(chooser[train_idx],
                                               upd_ent.bimod_ok,
                                               upd_ent.gshare_ok);
        end
    end

    // Drain-then-clear sequencer; clear_done is registered off the last walk step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_RUN;
            walk       <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                S_RUN:   if (clear_req) state <= S_DRAIN;
                S_DRAIN: if (count == '0) state <= S_CLEAR;
                S_CLEAR: begin
                    walk <= walk + 1'b1;
                    if (walk == WALK_LAST) begin
                        state      <= S_RUN;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign fetch_idx         = pc_at_fetch[CHOOSER_BITS+1:2];
    assign predictor_choice  = (state != S_CLEAR) && chooser[fetch_idx][1];
    assign clear_busy        = (state != S_RUN);
    assign unused_fetch_bits = ^{pc_at_fetch[31:CHOOSER_BITS+2], pc_at_fetch[1:0]};

endmodule

// File: tb/tb_btb_update_sched.sv
// tb_btb_update_sched: random and directed stimulus against a queue/array
// reference model of the update scheduler, compared every cycle, plus
// hand-computed literal expectations for the documented scenarios.
module tb_btb_update_sched;
    import btb_update_sched_pkg::*;

    localparam int QD  = 4;
    localparam int CB  = 10;
    localparam int TBL = 1 << CB;

    logic          clk = 1'b0;
    logic          rst;
    rob_to_btb_bus commit0, commit1, btb_upd;
    logic [1:0]    commit_bimod_ok, commit_gshare_ok;
    logic          commit_ready, btb_hold, predictor_choice;
    logic          clear_req, clear_busy, clear_done;
    logic [31:0]   pc_at_fetch;

    always #5 clk = ~clk;

    btb_update_sched #(.QUEUE_DEPTH(QD), .QUEUE_PTR_BITS(2), .CHOOSER_BITS(CB)) dut (
        .clk(clk), .rst(rst), .commit0(commit0), .commit1(commit1),
        .commit_bimod_ok(commit_bimod_ok), .commit_gshare_ok(commit_gshare_ok),
        .commit_ready(commit_ready), .btb_hold(btb_hold), .btb_upd(btb_upd),
        .pc_at_fetch(pc_at_fetch), .predictor_choice(predictor_choice),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    btb_sched_entry_t mq[$];
    int mst;     // 0 run, 1 drain, 2 clear
    int mwalk;
    bit mdone;
    int mch [TBL];

    // Last values seen by step()
    logic        obs_valid, obs_ready, obs_busy, obs_done, obs_choice;
    logic [31:0] obs_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rob_to_btb_bus mk(input bit v, input bit r, input bit br,
                                         input bit jal, input logic [31:0] pc);
        rob_to_btb_bus b;
        b.valid = v; b.ready = r; b.branch_inst = br; b.jal_inst = jal;
        b.taken = pc[3]; b.pc = pc; b.target = pc ^ 32'h0000_5a50;
        return b;
    endfunction

    function automatic bit qual(input rob_to_btb_bus c, input bit room);
        return c.valid && c.ready && (c.branch_inst || c.jal_inst) && room;
    endfunction

    task automatic model_reset();
        mq.delete();
        mst = 0; mwalk = 0; mdone = 0;
        for (int i = 0; i < TBL; i++) mch[i] = 1;
    endtask

    task automatic idle();
        commit0 = '0; commit1 = '0;
        commit_bimod_ok = 2'b00; commit_gshare_ok = 2'b00;
        clear_req = 1'b0; btb_hold = 1'b0;
    endtask

    // One clock: compare outputs with the model, advance the model, cross the edge.
    task automatic step();
        int cnt, idx;
        bit room, q0, q1, byp, iss, fire, exp_choice;
        btb_sched_entry_t e, e0, e1;
        @(negedge clk);
        cnt  = mq.size();
        room = (cnt <= QD-2);
        q0   = qual(commit0, room);
        q1   = qual(commit1, room);
        e0.bus = commit0; e0.bimod_ok = commit_bimod_ok[0]; e0.gshare_ok = commit_gshare_ok[0];
        e1.bus = commit1; e1.bimod_ok = commit_bimod_ok[1]; e1.gshare_ok = commit_gshare_ok[1];
        byp = 1'b0;
`ifdef BTB_SCHED_BYPASS_EN
        byp = (cnt == 0) && (mst == 0) && !btb_hold && (q0 != q1);
`endif
        iss  = (cnt > 0) && !btb_hold && (mst != 2);
        fire = iss || byp;
        e = '0;
        if (iss) e = mq[0];
        else if (byp) e = q0 ? e0 : e1;
        exp_choice = (mst != 2) && (mch[int'(pc_at_fetch[CB+1:2])] >= 2);

        chk("commit_ready", commit_ready, room);
        chk("upd_valid", btb_upd.valid, fire);
        chk("upd_ready", btb_upd.ready, fire);
        if (fire) begin
            chk("upd_pc", btb_upd.pc, e.bus.pc);
            chk("upd_target", btb_upd.target, e.bus.target);
            chk("upd_kind", {btb_upd.branch_inst, btb_upd.jal_inst, btb_upd.taken},
                {e.bus.branch_inst, e.bus.jal_inst, e.bus.taken});
        end
        chk("predictor_choice", predictor_choice, exp_choice);
        chk("clear_busy", clear_busy, mst != 0);
        chk("clear_done", clear_done, mdone);

        obs_valid = btb_upd.valid; obs_pc = btb_upd.pc; obs_ready = commit_ready;
        obs_busy = clear_busy; obs_done = clear_done; obs_choice = predictor_choice;

        if (fire && e.bus.branch_inst) begin
            idx = int'(e.bus.pc[CB+1:2]);
            if (e.gshare_ok && !e.bimod_ok && mch[idx] < 3) mch[idx]++;
            else if (e.bimod_ok && !e.gshare_ok && mch[idx] > 0) mch[idx]--;
        end
        if (iss) void'(mq.pop_front());
        if (!byp) begin
            if (q0) mq.push_back(e0);
            if (q1) mq.push_back(e1);
        end
        mdone = 1'b0;
        case (mst)
            0: if (clear_req) mst = 1;
            1: if (cnt == 0) mst = 2;
            default: begin
                mch[mwalk] = 1;
                if (mwalk == TBL-1) begin mst = 0; mwalk = 0; mdone = 1'b1; end
                else mwalk++;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    // Single branch through slot 0, then one idle cycle so it has issued.
    task automatic send1(input logic [31:0] pc, input bit bok, input bit gok);
        commit0 = mk(1, 1, 1, 0, pc);
        commit_bimod_ok = {1'b0, bok}; commit_gshare_ok = {1'b0, gok};
        step();
        idle();
        step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_order [4];
    int nbusy, ndone;

    initial begin
        idle();
        pc_at_fetch = 32'h200;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_commit_ready", commit_ready, 1'b1);
        chk("rst_upd_valid", btb_upd.valid, 1'b0);
        chk("rst_upd_ready", btb_upd.ready, 1'b0);
        chk("rst_choice", predictor_choice, 1'b0);
        chk("rst_clear_busy", clear_busy, 1'b0);
        chk("rst_clear_done", clear_done, 1'b0);
        release_reset();

        // Two commits in one cycle drain in order over the next two cycles.
        commit0 = mk(1, 1, 1, 0, 32'h100);
        commit1 = mk(1, 1, 0, 1, 32'h104);
        step();
        idle();
        step();
        chk("order_first_valid", obs_valid, 1'b1);
        chk("order_first_pc", obs_pc, 32'h100);
        step();
        chk("order_second_pc", obs_pc, 32'h104);
        step();
        chk("order_empty_after", obs_valid, 1'b0);

        // Hold while 2/cycle arrive: ready drops once full, order preserved.
        btb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            commit0 = mk(1, 1, 1, 0, 32'h500 + 32'(c*8));
            commit1 = mk(1, 1, 1, 0, 32'h504 + 32'(c*8));
            step();
            chk("hold_ready", obs_ready, (c < 2) ? 1'b1 : 1'b0);
        end
        idle();
        exp_order[0] = 32'h500; exp_order[1] = 32'h504;
        exp_order[2] = 32'h508; exp_order[3] = 32'h50c;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_drain_pc", obs_pc, exp_order[k]);
        end
        step();
        chk("hold_drain_empty", obs_valid, 1'b0);

        // Chooser training at pc 0x200: saturate at 3 then walk back down.
        pc_at_fetch = 32'h200;
        step();
        chk("chooser_init", obs_choice, 1'b0);
        for (int k = 0; k < 3; k++) send1(32'h200, 1'b0, 1'b1);
        step();
        chk("chooser_gshare", obs_choice, 1'b1);
        send1(32'h200, 1'b1, 1'b0);
        step();
        chk("chooser_sat_dec1", obs_choice, 1'b1);
        send1(32'h200, 1'b1, 1'b0);
        step();
        chk("chooser_sat_dec2", obs_choice, 1'b0);

        // Non-control commit on slot 1 alone is dropped.
        commit1 = mk(1, 1, 0, 0, 32'h300);
        step();
        chk("nonctrl_same", obs_valid, 1'b0);
        idle();
        step();
        chk("nonctrl_next", obs_valid, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            bit pres;
            int k0, k1;
            pres = commit_ready || ($urandom_range(0, 9) == 0);
            k0 = $urandom_range(0, 3);
            k1 = $urandom_range(0, 3);
            commit0 = mk(pres && ($urandom_range(0, 3) != 0), $urandom_range(0, 9) != 0,
                         (k0 == 1) || (k0 == 3), k0 == 2, 32'h1000 + 32'($urandom_range(0, 15) * 4));
            commit1 = mk(pres && ($urandom_range(0, 3) != 0), $urandom_range(0, 9) != 0,
                         (k1 == 1) || (k1 == 3), k1 == 2, 32'h1000 + 32'($urandom_range(0, 15) * 4));
            commit_bimod_ok  = 2'($urandom_range(0, 3));
            commit_gshare_ok = 2'($urandom_range(0, 3));
            btb_hold    = ($urandom_range(0, 2) == 0);
            pc_at_fetch = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            step();
        end
        idle();
        repeat (5) step();

        // Drain two queued entries, then the full clear walk.
        btb_hold = 1'b1;
        commit0 = mk(1, 1, 1, 0, 32'h600);
        commit1 = mk(1, 1, 1, 0, 32'h604);
        step();
        idle();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        nbusy = 0; ndone = 0;
        for (int c = 0; c < 1100 && ndone == 0; c++) begin
            pc_at_fetch = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            step();
            if (obs_busy) nbusy++;
            if (obs_done) ndone++;
        end
        chk("clear_done_seen", ndone, 1);
        chk("clear_busy_cycles", nbusy, 2 + TBL);
        for (int i = 0; i < TBL; i++) begin
            pc_at_fetch = 32'(i * 4);
            step();
            chk("after_clear_choice", obs_choice, 1'b0);
        end

        // Bias probes to 0, start a clear, reset at walk 500.
        for (int p = 0; p < 8; p++) begin
            send1(32'((600 + p) * 4), 1'b1, 1'b0);
            send1(32'((600 + p) * 4), 1'b1, 1'b0);
        end
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        repeat (500) step();
        chk("walk_reached", mwalk, 500);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("midclr_busy", clear_busy, 1'b0);
        chk("midclr_done", clear_done, 1'b0);
        chk("midclr_ready", commit_ready, 1'b1);
        chk("midclr_upd_valid", btb_upd.valid, 1'b0);
        release_reset();
        for (int i = 0; i < TBL; i++) begin
            pc_at_fetch = 32'(i * 4);
            step();
        end
        for (int p = 0; p < 8; p++) begin
            pc_at_fetch = 32'((600 + p) * 4);
            send1(32'((600 + p) * 4), 1'b0, 1'b1);
            step();
            chk("midclr_probe_choice", obs_choice, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
